fir_inverse_filter: RTL and testbench
=====================================

// Module: fir_inverse_filter
// PURPOSE
//  Recovers the 8-bit sample stream x[n] from the 16-bit output y[n] of the 4-tap FIR (h0=1,h1..h3).
//  Runs the exact recursive inverse x[n] = y[n] - H1*x[n-1] - H2*x[n-2] - H3*x[n-3], with h0=1, so there is no divider.
//  Sits at the receive end of the filtered-sample path, for loopback checks and equalisation.
//  Valid/ready handshake on both sides. Single-entry output register. Saturating 8-bit result.
// PARAMETERS
//  H1  2  signed 8-bit tap-1 coefficient (must match the forward FIR)
//  H2  3  signed 8-bit tap-2 coefficient
//  H3  4  signed 8-bit tap-3 coefficient
// PORTS
//  clk        in   1   rising-edge clock; the only clock
//  rst_n      in   1   asynchronous, active-low reset
//  clear      in   1   sync flush: zeroes history and output register, drops pending output
//  y_in       in   16  signed filtered sample
//  y_valid    in   1   y_in valid
//  y_ready    out  1   block can accept y_in this cycle
//  x_out      out  8   signed recovered sample
//  x_valid    out  1   x_out valid
//  x_ready    in   1   downstream accepts x_out
//  sat_pulse  out  1   1-cycle pulse: the sample just loaded into x_out was clamped
//  sat_sticky out  1   any clamp since reset/clear
//  sample_cnt out  16  count of accepted y samples; wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (rst_n=0, async): x1=x2=x3=0; x_out=0; x_valid=0; sat_pulse=0; sat_sticky=0; sample_cnt=0.
//   Takes effect immediately, including mid-transfer. A pending x_out is discarded.
//  Output register states:
//   EMPTY (x_valid=0): y_ready=1.
//   FULL (x_valid=1): y_ready=x_ready, so a drain and a refill can happen in the same cycle.
//  Accept = y_valid & y_ready. On accept, at the next edge:
//   x_out <= clamp(acc); x_valid <= 1; x3<=x2; x2<=x1; x1<=clamp(acc); sample_cnt++.
//  Latency: 1 cycle, accept -> x_valid. Sustained throughput: 1 sample/cycle while x_ready=1.
//  Transitions: FULL & x_ready & no accept -> EMPTY (x_valid<=0). FULL & !x_ready -> hold x_out stable.
//  Arithmetic:
//   acc is 19-bit signed: sext(y_in) - H1*x1 - H2*x2 - H3*x3; each product is 16-bit signed.
//   clamp: acc>127 -> 127; acc<-128 -> -128; otherwise acc[7:0].
//   History stores the clamped value, so recovery after a clamp is deterministic.
//  sat_pulse=1 for exactly the cycle after a clamping accept; else 0. sat_sticky is set by the same event.
//  clear=1 (sync): history=0, x_valid=0, x_out=0, sat_sticky=0, sample_cnt=0; y_ready=0 this cycle.
//   clear has priority over a simultaneous accept; that y sample is dropped.
//  No accept while y_valid=0: history, x_out and sample_cnt hold.
//  x_out, x_valid and flags are registered; y_ready is combinational from x_valid and x_ready.
// TESTING
//  Impulse: y=1,2,3,4,0,0 with x_ready=1 -> x_out=1,0,0,0,0,0; sat_sticky=0.
//  Step: y=10,30,60,100,100 -> x_out=10,10,10,10,10. Also drive the forward FIR with random
//   8-bit input and feed its output here -> output equals the original input, zero clamps.
//  Backpressure: x_ready=0 for 5 cycles with y_valid=1 -> y_ready=0, x_out held, no sample lost;
//   on release, one sample/cycle and sample_cnt matches the number of accepts.
//  Saturation: y=200 from reset -> x_out=127, sat_pulse for 1 cycle, sat_sticky=1.
//   Next y=254 -> x_out=0 (254-2*127), no new pulse.
//  Flush/reset: clear with y_valid=1 and history nonzero -> sample dropped, next y=5 gives x_out=5.
//   rst_n low mid-burst -> all outputs 0 asynchronously.
//  Counter wrap: preload via 65536 accepts -> sample_cnt returns to 0.

Source files
------------

// File: rtl/fir_inverse_filter_if.sv
// Sample stream bundle for the FIR inverse filter: filtered y samples in,
// recovered x samples out, each side with its own valid/ready pair.
interface fir_inverse_filter_if;
  logic signed [15:0] y_in;
  logic               y_valid;
  logic               y_ready;
  logic signed [7:0]  x_out;
  logic               x_valid;
  logic               x_ready;

  modport master (output y_in, y_valid, x_ready, input  y_ready, x_out, x_valid);
  modport slave  (input  y_in, y_valid, x_ready, output y_ready, x_out, x_valid);
endinterface

// File: rtl/fir_inverse_filter.sv
// Exact recursive inverse of a 4-tap FIR with h0=1: x[n] = y[n] - H1*x[n-1] - H2*x[n-2] - H3*x[n-3].
// Saturates to 8 bits and keeps the clamped value in the history so recovery stays deterministic.
module fir_inverse_filter #(
  parameter logic signed [7:0] H1 = 8'sd2,
  parameter logic signed [7:0] H2 = 8'sd3,
  parameter logic signed [7:0] H3 = 8'sd4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear_i,
  fir_inverse_filter_if.slave bus,
  output logic                sat_pulse_o,
  output logic                sat_sticky_o,
  output logic [15:0]         sample_cnt_o
);

  typedef enum logic {S_EMPTY, S_FULL} state_e;

  state_e             state_q, state_d;
  logic signed [7:0]  x1_q, x1_d, x2_q, x2_d, x3_q, x3_d;
  logic signed [7:0]  xout_q, xout_d;
  logic               pulse_q, pulse_d;
  logic               sticky_q, sticky_d;
  logic [15:0]        cnt_q, cnt_d;

  logic signed [15:0] p1, p2, p3;
  logic signed [18:0] acc;
  logic signed [7:0]  xclamp;
  logic               clamped;
  logic               accept;

  // Products are full 16-bit signed; accumulator has headroom for the worst-case sum.
  assign p1  = 16'(H1) * 16'(x1_q);
  assign p2  = 16'(H2) * 16'(x2_q);
  assign p3  = 16'(H3) * 16'(x3_q);
  assign acc = 19'(bus.y_in) - 19'(p1) - 19'(p2) - 19'(p3);

  always_comb begin
    xclamp  = $signed(acc[7:0]);
    clamped = 1'b0;
    if (acc > 19'sd127) begin
      xclamp  = 8'sd127;
      clamped = 1'b1;
    end else if (acc < -19'sd128) begin
      xclamp  = -8'sd128;
      clamped = 1'b1;
    end
  end

  // ---- output-register FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_EMPTY;
    else        state_q <= state_d;
  end

  // ---- next state
  always_comb begin
    state_d = state_q;
    if (clear_i)                             state_d = S_EMPTY;
    else if (accept)                         state_d = S_FULL;
    else if (state_q == S_FULL && bus.x_ready) state_d = S_EMPTY;
  end

  // ---- outputs; a full register frees up only when downstream drains it this cycle
  always_comb begin
    bus.y_ready = !clear_i && (state_q == S_EMPTY || bus.x_ready);
    bus.x_valid = (state_q == S_FULL);
  end

  assign accept = bus.y_valid && bus.y_ready;

  // ---- datapath next state; clear wins over a simultaneous accept
  always_comb begin
    x1_d     = x1_q;
    x2_d     = x2_q;
    x3_d     = x3_q;
    xout_d   = xout_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    pulse_d  = 1'b0;
    if (clear_i) begin
      x1_d     = '0;
      x2_d     = '0;
      x3_d     = '0;
      xout_d   = '0;
      cnt_d    = '0;
      sticky_d = 1'b0;
    end else if (accept) begin
      xout_d   = xclamp;
      x1_d     = xclamp;
      x2_d     = x1_q;
      x3_d     = x2_q;
      cnt_d    = cnt_q + 16'd1;
      pulse_d  = clamped;
      sticky_d = sticky_q | clamped;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x1_q     <= '0;
      x2_q     <= '0;
      x3_q     <= '0;
      xout_q   <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      x1_q     <= x1_d;
      x2_q     <= x2_d;
      x3_q     <= x3_d;
      xout_q   <= xout_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      pulse_q  <= pulse_d;
    end
  end

  assign bus.x_out    = xout_q;
  assign sat_pulse_o  = pulse_q;
  assign sat_sticky_o = sticky_q;
  assign sample_cnt_o = cnt_q;

endmodule

// File: tb/tb_fir_inverse_filter.sv
// Directed bench for fir_inverse_filter: impulse, step, forward-FIR loopback,
// backpressure, saturation, flush, async reset and counter wrap.
module tb_fir_inverse_filter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear_i = 1'b0;
  logic        sat_pulse_o, sat_sticky_o;
  logic [15:0] sample_cnt_o;
  int          n_chk = 0;
  int          n_fail = 0;

  fir_inverse_filter_if bus();

  fir_inverse_filter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (clear_i),
    .bus         (bus),
    .sat_pulse_o (sat_pulse_o),
    .sat_sticky_o(sat_sticky_o),
    .sample_cnt_o(sample_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_clear();
    clear_i = 1'b1; bus.y_valid = 1'b0; tick(); clear_i = 1'b0;
  endtask

  task automatic test_reset();
    bus.y_in = '0; bus.y_valid = 1'b0; bus.x_ready = 1'b1;
    rst_n = 1'b0;
    tick(); tick();
    n_chk++; if (bus.x_valid !== 1'b0) begin n_fail++; $display("FAIL reset_x_valid got %0b want 0", bus.x_valid); end
    n_chk++; if (bus.x_out !== 8'sd0) begin n_fail++; $display("FAIL reset_x_out got %0d want 0", $signed(bus.x_out)); end
    n_chk++; if (sample_cnt_o !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", sample_cnt_o); end
    n_chk++; if (sat_sticky_o !== 1'b0 || sat_pulse_o !== 1'b0) begin n_fail++; $display("FAIL reset_flags got %0b%0b want 00", sat_pulse_o, sat_sticky_o); end
    rst_n = 1'b1; #1;
    n_chk++; if (bus.y_ready !== 1'b1) begin n_fail++; $display("FAIL reset_y_ready got %0b want 1", bus.y_ready); end
  endtask

  task automatic test_impulse();
    int ys[6] = '{1, 2, 3, 4, 0, 0};
    int xs[6] = '{1, 0, 0, 0, 0, 0};
    bus.x_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.y_in = 16'(ys[i]); bus.y_valid = 1'b1; tick();
      n_chk++;
      if (bus.x_out !== 8'(xs[i]) || bus.x_valid !== 1'b1) begin
        n_fail++; $display("FAIL impulse[%0d] got %0d/v%0b want %0d/v1", i, $signed(bus.x_out), bus.x_valid, xs[i]);
      end
    end
    bus.y_valid = 1'b0;
    n_chk++; if (sat_sticky_o !== 1'b0) begin n_fail++; $display("FAIL impulse_sticky got %0b want 0", sat_sticky_o); end
    n_chk++; if (sample_cnt_o !== 16'd6) begin n_fail++; $display("FAIL impulse_cnt got %0d want 6", sample_cnt_o); end
  endtask

  task automatic test_step();
    int ys[5] = '{10, 30, 60, 100, 100};
    do_clear();
    for (int i = 0; i < 5; i++) begin
      bus.y_in = 16'(ys[i]); bus.y_valid = 1'b1; tick();
      n_chk++;
      if (bus.x_out !== 8'sd10) begin n_fail++; $display("FAIL step[%0d] got %0d want 10", i, $signed(bus.x_out)); end
    end
    bus.y_valid = 1'b0;
  endtask

  // Forward FIR in the bench feeds the DUT; the DUT must return the original samples.
  task automatic test_fir_loopback();
    int h1 = 0, h2 = 0, h3 = 0, xn, yn;
    do_clear();
    for (int i = 0; i < 24; i++) begin
      xn = int'($urandom_range(0, 255)) - 128;
      yn = xn + 2 * h1 + 3 * h2 + 4 * h3;
      bus.y_in = 16'(yn); bus.y_valid = 1'b1; tick();
      n_chk++;
      if (bus.x_out !== 8'(xn)) begin n_fail++; $display("FAIL loopback[%0d] got %0d want %0d", i, $signed(bus.x_out), xn); end
      h3 = h2; h2 = h1; h1 = xn;
    end
    bus.y_valid = 1'b0;
    n_chk++; if (sat_sticky_o !== 1'b0) begin n_fail++; $display("FAIL loopback_sticky got %0b want 0", sat_sticky_o); end
  endtask

  // Source x = 5, 7, -3, 1 -> y = 5, 17, 26, 36.
  task automatic test_backpressure();
    int ys[3] = '{17, 26, 36};
    int xs[3] = '{7, -3, 1};
    do_clear();
    bus.x_ready = 1'b1; bus.y_in = 16'sd5; bus.y_valid = 1'b1; tick();
    n_chk++; if (bus.x_out !== 8'sd5) begin n_fail++; $display("FAIL bp_first got %0d want 5", $signed(bus.x_out)); end
    bus.x_ready = 1'b0; bus.y_in = 16'sd17; #1;
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (bus.y_ready !== 1'b0 || bus.x_out !== 8'sd5 || bus.x_valid !== 1'b1 || sample_cnt_o !== 16'd1) begin
        n_fail++; $display("FAIL bp_stall[%0d] rdy=%0b x=%0d v=%0b cnt=%0d want rdy=0 x=5 v=1 cnt=1",
                           i, bus.y_ready, $signed(bus.x_out), bus.x_valid, sample_cnt_o);
      end
      tick();
    end
    bus.x_ready = 1'b1; #1;
    n_chk++; if (bus.y_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_rdy got %0b want 1", bus.y_ready); end
    for (int i = 0; i < 3; i++) begin
      bus.y_in = 16'(ys[i]); tick();
      n_chk++;
      if (bus.x_out !== 8'(xs[i])) begin n_fail++; $display("FAIL bp_drain[%0d] got %0d want %0d", i, $signed(bus.x_out), xs[i]); end
    end
    bus.y_valid = 1'b0;
    n_chk++; if (sample_cnt_o !== 16'd4) begin n_fail++; $display("FAIL bp_cnt got %0d want 4", sample_cnt_o); end
    tick();
    n_chk++; if (bus.x_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %0b want 0", bus.x_valid); end
  endtask

  task automatic test_saturation();
    do_clear();
    bus.y_in = 16'sd200; bus.y_valid = 1'b1; tick();
    n_chk++; if (bus.x_out !== 8'sd127 || sat_pulse_o !== 1'b1 || sat_sticky_o !== 1'b1) begin
      n_fail++; $display("FAIL sat_hi got x=%0d p=%0b s=%0b want 127/1/1", $signed(bus.x_out), sat_pulse_o, sat_sticky_o); end
    bus.y_in = 16'sd254; tick();
    n_chk++; if (bus.x_out !== 8'sd0 || sat_pulse_o !== 1'b0 || sat_sticky_o !== 1'b1) begin
      n_fail++; $display("FAIL sat_recover got x=%0d p=%0b s=%0b want 0/0/1", $signed(bus.x_out), sat_pulse_o, sat_sticky_o); end
    // -1000 - 2*0 - 3*127 = -1381
    bus.y_in = -16'sd1000; tick();
    n_chk++; if (bus.x_out !== -8'sd128 || sat_pulse_o !== 1'b1) begin
      n_fail++; $display("FAIL sat_lo got x=%0d p=%0b want -128/1", $signed(bus.x_out), sat_pulse_o); end
    bus.y_valid = 1'b0; tick();
    n_chk++; if (sat_pulse_o !== 1'b0 || sat_sticky_o !== 1'b1) begin
      n_fail++; $display("FAIL sat_pulse_end got p=%0b s=%0b want 0/1", sat_pulse_o, sat_sticky_o); end
  endtask

  task automatic test_flush();
    clear_i = 1'b1; bus.y_in = 16'sd77; bus.y_valid = 1'b1; #1;
    n_chk++; if (bus.y_ready !== 1'b0) begin n_fail++; $display("FAIL flush_rdy got %0b want 0", bus.y_ready); end
    tick(); clear_i = 1'b0;
    n_chk++; if (bus.x_valid !== 1'b0 || bus.x_out !== 8'sd0 || sat_sticky_o !== 1'b0 || sample_cnt_o !== 16'd0) begin
      n_fail++; $display("FAIL flush_state got v=%0b x=%0d s=%0b cnt=%0d want 0/0/0/0",
                         bus.x_valid, $signed(bus.x_out), sat_sticky_o, sample_cnt_o); end
    bus.y_in = 16'sd5; tick();
    n_chk++; if (bus.x_out !== 8'sd5 || sample_cnt_o !== 16'd1) begin
      n_fail++; $display("FAIL flush_next got x=%0d cnt=%0d want 5/1", $signed(bus.x_out), sample_cnt_o); end
    bus.y_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    do_clear();
    bus.y_in = 16'sd200; bus.y_valid = 1'b1; tick();   // clamps to 127, sticky set
    bus.y_in = 16'sd257; tick();                        // 257 - 254 = 3
    n_chk++; if (bus.x_out !== 8'sd3 || sample_cnt_o !== 16'd2) begin
      n_fail++; $display("FAIL areset_pre got x=%0d cnt=%0d want 3/2", $signed(bus.x_out), sample_cnt_o); end
    rst_n = 1'b0; #2;
    n_chk++; if (bus.x_valid !== 1'b0 || bus.x_out !== 8'sd0 || sample_cnt_o !== 16'd0 || sat_sticky_o !== 1'b0) begin
      n_fail++; $display("FAIL areset_async got v=%0b x=%0d cnt=%0d s=%0b want 0/0/0/0",
                         bus.x_valid, $signed(bus.x_out), sample_cnt_o, sat_sticky_o); end
    bus.y_valid = 1'b0; tick(); rst_n = 1'b1;
  endtask

  task automatic test_counter_wrap();
    bus.y_in = '0; bus.y_valid = 1'b1; bus.x_ready = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    n_chk++; if (sample_cnt_o !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_max got %0h want ffff", sample_cnt_o); end
    tick();
    bus.y_valid = 1'b0;
    n_chk++; if (sample_cnt_o !== 16'd0 || bus.x_out !== 8'sd0) begin
      n_fail++; $display("FAIL wrap_zero got cnt=%0h x=%0d want 0/0", sample_cnt_o, $signed(bus.x_out)); end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_step();
    test_fir_loopback();
    test_backpressure();
    test_saturation();
    test_flush();
    test_async_reset();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
